// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
// Provides the occupancy state encoding (state value == entries held)
// and the occupancy output width.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset, clears count
//   inc    - add one this cycle (ignored once count is all ones)
//   clr    - synchronous clear, overrides inc
//   count  - current count value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional
// two-entry skid buffer, stall/flush control, occupancy output and a
// saturating back-pressure counter.
// Ports:
//   clk, reset           - clock; asynchronous active-low reset
//   stall                - freeze stage (no accept, no emit)
//   flush                - synchronous kill of all held entries
//   in_valid/in_ready    - upstream handshake, in_data payload
//   out_valid/out_ready  - downstream handshake, out_data payload (registered)
//   occupancy            - entries held (0..2)
//   bp_cnt/bp_clr        - back-pressured cycle count and its clear
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  bp_cnt,
  input  logic              bp_clr
);

  occ_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic main_v, skid_v;
  logic acc_in, acc_out;

  assign main_v = (state_q != ST_EMPTY);
  assign skid_v = (state_q == ST_FULL);

  // With the skid buffer, in_ready depends only on local state, breaking
  // the combinational out_ready -> in_ready path.
  always_comb begin
    if (SKID != 0) begin
      in_ready = ~skid_v & ~stall & ~flush;
    end else begin
      in_ready = (~main_v | (out_ready & ~stall)) & ~flush & ~stall;
    end
  end

  assign acc_in  = in_valid & in_ready;
  assign acc_out = main_v & out_ready & ~stall;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_DATA != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc_in) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (acc_in && acc_out) begin
            main_d = in_data;
          end else if (acc_in) begin
            // Only reachable with the skid buffer; SKID=0 accepts in ONE
            // only when the head is leaving the same cycle.
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (acc_out) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (acc_out) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = state_q;

  sat_counter #(
    .W (CNT_W)
  ) u_bp_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (main_v & ~acc_out),
    .clr   (bp_clr),
    .count (bp_cnt)
  );

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three configurations driven by shared stimulus,
// each compared every cycle with a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int NI = 3;
  localparam int SKID_P [NI] = '{1, 1, 0};
  localparam int CLR_P  [NI] = '{1, 0, 1};
  localparam int MAX_P  [NI] = '{15, 65535, 15};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, bp_clr = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        ir [NI];
  logic        ov [NI];
  logic [31:0] od [NI];
  logic [1:0]  oc [NI];
  logic [3:0]  bp_a, bp_c;
  logic [15:0] bp_b;
  logic [15:0] bpo [NI];

  int checks = 0;
  int failures = 0;

  // reference model: queue contents, count, stale head value, bp count
  logic [31:0] mq [NI][2];
  int          mn [NI];
  logic [31:0] mstale [NI];
  int          mbp [NI];

  always #5 clk = ~clk;

  always_comb begin
    bpo[0] = 16'(bp_a);
    bpo[1] = bp_b;
    bpo[2] = 16'(bp_c);
  end

  pipe_skid_reg #(.DATA_W(32), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(oc[0]), .bp_cnt(bp_a), .bp_clr(bp_clr));

  pipe_skid_reg #(.DATA_W(32), .SKID(1), .CLEAR_DATA(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(oc[1]), .bp_cnt(bp_b), .bp_clr(bp_clr));

  pipe_skid_reg #(.DATA_W(32), .SKID(0), .CLEAR_DATA(1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(oc[2]), .bp_cnt(bp_c), .bp_clr(bp_clr));

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int k);
    if (SKID_P[k] != 0)
      return (mn[k] < 2) && !stall && !flush;
    return ((mn[k] == 0) || (out_ready && !stall)) && !flush && !stall;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mn[k] = 0; mstale[k] = '0; mbp[k] = 0;
      mq[k][0] = '0; mq[k][1] = '0;
    end
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < NI; k++) begin
      check("rst_out_valid", k, 32'(ov[k]), 32'd0);
      check("rst_occupancy", k, 32'(oc[k]), 32'd0);
      check("rst_bp_cnt",    k, 32'(bpo[k]), 32'd0);
      check("rst_out_data",  k, od[k], 32'd0);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check("in_ready",  k, 32'(ir[k]), 32'(exp_ready(k)));
      check("out_valid", k, 32'(ov[k]), 32'(mn[k] > 0));
      check("occupancy", k, 32'(oc[k]), 32'(mn[k]));
      check("out_data",  k, od[k], (mn[k] > 0) ? mq[k][0] : mstale[k]);
      check("bp_cnt",    k, 32'(bpo[k]), 32'(mbp[k]));
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      logic ai, ao;
      logic [31:0] h;
      ao = (mn[k] > 0) && out_ready && !stall;
      ai = in_valid && exp_ready(k);
      if (bp_clr) mbp[k] = 0;
      else if ((mn[k] > 0) && !ao && (mbp[k] < MAX_P[k])) mbp[k]++;
      if (flush) begin
        if (CLR_P[k] != 0) mstale[k] = '0;
        else if (mn[k] > 0) mstale[k] = mq[k][0];
        mn[k] = 0;
      end else begin
        if (ao) begin
          h = mq[k][0];
          mq[k][0] = mq[k][1];
          mn[k]--;
          if (mn[k] == 0) mstale[k] = h;
        end
        if (ai) begin
          mq[k][mn[k]] = in_data;
          mn[k]++;
        end
      end
    end
  endtask

  // Called at posedge+1; compares mid-cycle, advances model, returns at posedge+1.
  task automatic tick();
    #4;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic st, input logic fl, input logic clr);
    in_valid = iv; in_data = d; out_ready = ordy;
    stall = st; flush = fl; bp_clr = clr;
  endtask

  initial begin
    model_reset();
    // reset held with live input
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_reset_state();
    @(posedge clk); #1;
    check_reset_state();
    reset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();

    // back-pressure A, B, C
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0); tick(); tick();
    drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();

    // stall with full stage
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h33, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();

    // flush with pending 0x77, then flush together with stall
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); tick();
    drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); tick();

    // counter saturation and clear
    drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); tick();

    // asynchronous reset mid-traffic
    drive(1'b1, 32'hAB, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hCD, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    #2 reset = 1'b0;
    #1 check_reset_state();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 32'hEF, 1'b1, 1'b0, 1'b0, 1'b0); tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9, 0) < 7, $urandom, $urandom_range(9, 0) < 6,
            $urandom_range(9, 0) < 1, $urandom_range(24, 0) < 1,
            $urandom_range(29, 0) < 1);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_skid_reg
